// File: rtl/pos_bcd_encoder.sv
// Converts the cursor's binary X/Y cell coordinates into two-digit BCD for the
// 7-segment decoder, one bit per clock via shift-add-3 for both axes in parallel.
module pos_bcd_encoder #(
    parameter int X_WIDTH    = 7,
    parameter int Y_WIDTH    = 7,
    parameter bit AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x_pos,
    input  logic [Y_WIDTH-1:0] y_pos,
    output logic [3:0]         x_ones,
    output logic [3:0]         x_tens,
    output logic [3:0]         y_ones,
    output logic [3:0]         y_tens,
    output logic               x_ovf,
    output logic               y_ovf,
    output logic               busy,
    output logic               done
);

    localparam int N  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      bit_cnt;
    logic [N-1:0]       x_bin;
    logic [N-1:0]       y_bin;
    logic [7:0]         x_bcd;
    logic [7:0]         y_bcd;
    logic               x_ovf_work;
    logic               y_ovf_work;
    logic [X_WIDTH-1:0] x_last;
    logic [Y_WIDTH-1:0] y_last;
    logic               pair_changed;
    logic               trigger;
    logic               last_shift;

    function automatic logic [7:0] add3(input logic [7:0] bcd);
        logic [7:0] r;
        r[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        r[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        return r;
    endfunction

    // Hundreds carry out of the tens nibble is dropped; such values are
    // flagged as overflow and never displayed from the accumulator.
    function automatic logic [7:0] dabble(input logic [7:0] bcd, input logic msb);
        return 8'({add3(bcd), msb});
    endfunction

    function automatic logic over_99(input logic [N-1:0] v);
        return 32'(v) > 32'd99;
    endfunction

    assign pair_changed = (x_pos != x_last) || (y_pos != y_last);
    assign trigger      = start || (AUTO_START && pair_changed);
    assign last_shift   = (bit_cnt == LAST_BIT);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            x_bin      <= '0;
            y_bin      <= '0;
            x_bcd      <= '0;
            y_bcd      <= '0;
            x_ovf_work <= 1'b0;
            y_ovf_work <= 1'b0;
            x_last     <= '0;
            y_last     <= '0;
            x_ones     <= 4'd0;
            x_tens     <= 4'd0;
            y_ones     <= 4'd0;
            y_tens     <= 4'd0;
            x_ovf      <= 1'b0;
            y_ovf      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        x_bin      <= N'(x_pos);
                        y_bin      <= N'(y_pos);
                        x_last     <= x_pos;
                        y_last     <= y_pos;
                        x_ovf_work <= over_99(N'(x_pos));
                        y_ovf_work <= over_99(N'(y_pos));
                        x_bcd      <= '0;
                        y_bcd      <= '0;
                        bit_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    x_bcd   <= dabble(x_bcd, x_bin[N-1]);
                    y_bcd   <= dabble(y_bcd, y_bin[N-1]);
                    x_bin   <= x_bin << 1;
                    y_bin   <= y_bin << 1;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                DONE: begin
                    // All digits and flags land on one edge so the display never tears.
                    x_tens <= x_ovf_work ? 4'hF : x_bcd[7:4];
                    x_ones <= x_ovf_work ? 4'hF : x_bcd[3:0];
                    y_tens <= y_ovf_work ? 4'hF : y_bcd[7:4];
                    y_ones <= y_ovf_work ? 4'hF : y_bcd[3:0];
                    x_ovf  <= x_ovf_work;
                    y_ovf  <= y_ovf_work;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pos_bcd_encoder.sv
// Bench for pos_bcd_encoder: one instance with AUTO_START=0, one with AUTO_START=1,
// checked against an arithmetic decimal model and cycle-accurate timing.
module tb_pos_bcd_encoder;

    localparam int N = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [6:0] x0, y0, x1, y1;
    logic [3:0] xo0, xt0, yo0, yt0, xo1, xt1, yo1, yt1;
    logic       xv0, yv0, busy0, done0;
    logic       xv1, yv1, busy1, done1;
    logic [17:0] obs0, obs1;

    int tests  = 0;
    int failed = 0;
    int dcnt0  = 0;
    int dcnt1  = 0;

    pos_bcd_encoder #(.X_WIDTH(7), .Y_WIDTH(7), .AUTO_START(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .x_pos(x0), .y_pos(y0),
        .x_ones(xo0), .x_tens(xt0), .y_ones(yo0), .y_tens(yt0),
        .x_ovf(xv0), .y_ovf(yv0), .busy(busy0), .done(done0)
    );

    pos_bcd_encoder #(.X_WIDTH(7), .Y_WIDTH(7), .AUTO_START(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .x_pos(x1), .y_pos(y1),
        .x_ones(xo1), .x_tens(xt1), .y_ones(yo1), .y_tens(yt1),
        .x_ovf(xv1), .y_ovf(yv1), .busy(busy1), .done(done1)
    );

    assign obs0 = {xt0, xo0, yt0, yo0, xv0, yv0};
    assign obs1 = {xt1, xo1, yt1, yo1, xv1, yv1};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done0 === 1'b1) dcnt0++;
        if (done1 === 1'b1) dcnt1++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected display: decimal digits, or dashes (F,F) with the flag above 99.
    function automatic logic [17:0] model(input int x, input int y);
        logic [3:0] xt, xo, yt, yo;
        logic       xv, yv;
        xv = (x > 99);
        yv = (y > 99);
        xt = xv ? 4'hF : 4'(x / 10);
        xo = xv ? 4'hF : 4'(x % 10);
        yt = yv ? 4'hF : 4'(y / 10);
        yo = yv ? 4'hF : 4'(y % 10);
        return {xt, xo, yt, yo, xv, yv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv0(input string tag, input int x, input int y);
        int cyc;
        x0 = 7'(x);
        y0 = 7'(y);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 40) begin
            chk({tag, " busy"}, 32'(busy0), 32'd1);
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(N + 1));
        chk({tag, " busy_at_done"}, 32'(busy0), 32'd0);
        chk({tag, " digits"}, 32'(obs0), 32'(model(x, y)));
        tick();
        chk({tag, " done_width"}, 32'(done0), 32'd0);
        chk({tag, " hold"}, 32'(obs0), 32'(model(x, y)));
    endtask

    task automatic wait_d0(input string tag, input int budget);
        int cyc = 0;
        while (done0 !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk({tag, " reached_done"}, 32'(done0), 32'd1);
    endtask

    task automatic wait_d1(input string tag, input int budget);
        int cyc = 0;
        while (done1 !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk({tag, " reached_done"}, 32'(done1), 32'd1);
    endtask

    initial begin
        int before0, before1, rx, ry;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) tick();
        chk("reset digits0", 32'(obs0), 32'd0);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset done0", 32'(done0), 32'd0);
        chk("reset digits1", 32'(obs1), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        tick();

        conv0("basic", 57, 3);
        conv0("max99", 99, 0);
        conv0("ovf", 100, 127);
        conv0("zero", 0, 0);
        conv0("split_ovf", 5, 100);
        for (int i = 0; i < 10; i++) begin
            rx = int'($urandom_range(0, 127));
            ry = int'($urandom_range(0, 127));
            conv0("rand", rx, ry);
        end

        // Repeated start and an input change mid-conversion are both ignored.
        x0 = 7'd12; y0 = 7'd34; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        before0 = dcnt0;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        x0 = 7'd88;
        wait_d0("ign0", 30);
        chk("ign0 digits", 32'(obs0), 32'(model(12, 34)));
        repeat (20) tick();
        chk("ign0 pulses", 32'(dcnt0 - before0), 32'd1);
        chk("ign0 no_rerun", 32'(obs0), 32'(model(12, 34)));

        // Same sequence with auto-start: the change is picked up afterwards.
        x1 = 7'd12; y1 = 7'd34; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        before1 = dcnt1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        x1 = 7'd88;
        wait_d1("ign1", 30);
        chk("ign1 first", 32'(obs1), 32'(model(12, 34)));
        tick();
        wait_d1("ign1 second", 30);
        chk("ign1 second digits", 32'(obs1), 32'(model(88, 34)));
        repeat (20) tick();
        chk("ign1 pulses", 32'(dcnt1 - before1), 32'd2);

        // Auto-start on a single-step change, then silence while held.
        x1 = 7'd20;
        wait_d1("auto20", 30);
        chk("auto20 digits", 32'(obs1), 32'(model(20, 34)));
        x1 = 7'd21;
        tick();
        wait_d1("auto21", 30);
        chk("auto21 digits", 32'(obs1), 32'(model(21, 34)));
        chk("auto21 x_ones", 32'(xo1), 32'd1);
        tick();
        before1 = dcnt1;
        repeat (30) tick();
        chk("auto hold pulses", 32'(dcnt1 - before1), 32'd0);

        // Reset on the fourth edge of a conversion aborts it.
        x0 = 7'd45; y0 = 7'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        before0 = dcnt0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst done0", 32'(done0), 32'd0);
        chk("rst digits0", 32'(obs0), 32'd0);
        chk("rst digits1", 32'(obs1), 32'd0);
        reset = 1'b0;
        before1 = dcnt1;
        repeat (15) tick();
        chk("rst no_done0", 32'(dcnt0 - before0), 32'd0);
        chk("rst still0", 32'(obs0), 32'd0);
        chk("rst auto_rerun1", 32'(dcnt1 - before1), 32'd1);
        chk("rst auto_digits1", 32'(obs1), 32'(model(21, 34)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
